win_scan_ctrl: RTL and testbench

Sequencer that decides whether the disc just dropped into column `col` completes four-in-a-row. It sits between the game FSM and the board register file. It reads one 6-bit column at a time through a single read port, walks the four line directions out from the placed disc, and reports win, error and optionally draw with a one-cycle `done` pulse. It replaces a fully combinational 42-cell win checker with a small serial one.

---
 rtl/win_scan_pkg.sv | 30 +++
 rtl/win_scan_ctrl_if.sv | 28 ++
 rtl/win_scan_step.sv | 43 ++++
 rtl/win_scan_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_win_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/win_scan_pkg.sv
// Shared types and defaults for the serial four-in-a-row scanner.
// The board draw counter is compiled in only when WIN_SCAN_DRAW_EN is defined.
package win_scan_pkg;

  localparam int COLS_DEF    = 7;
  localparam int ROWS_DEF    = 6;
  localparam int WIN_LEN_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    FIND_WAIT,
    FIND_EVAL,
    STEP,
    PROBE_WAIT,
    PROBE_EVAL,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    DIR_H,
    DIR_V,
    DIR_D1,
    DIR_D2
  } dir_e;

  // Unit step per direction, indexed by dir_e: H, V, D1, D2.
  localparam logic signed [1:0] DIR_DX [4] = '{2'sb01, 2'sb00, 2'sb01, 2'sb01};
  localparam logic signed [1:0] DIR_DY [4] = '{2'sb00, 2'sb01, 2'sb01, 2'sb11};

endpackage

// File: rtl/win_scan_ctrl_if.sv
// Control and board-read bundle between the game FSM / board register file
// (master) and the win scanner (slave).
interface win_scan_ctrl_if #(
  parameter int ROWS = win_scan_pkg::ROWS_DEF
);
  logic            go;
  logic [2:0]      col;
  logic            player;
  logic            clear;
  logic [2:0]      rd_addr;
  logic [ROWS-1:0] rd_onoff;
  logic [ROWS-1:0] rd_player;
  logic            busy;
  logic            done;
  logic            win;
  logic            err;
  logic            draw;

  modport master (
    output go, col, player, clear, rd_onoff, rd_player,
    input  rd_addr, busy, done, win, err, draw
  );

  modport slave (
    input  go, col, player, clear, rd_onoff, rd_player,
    output rd_addr, busy, done, win, err, draw
  );
endinterface

// File: rtl/win_scan_step.sv
// Probe-cell calculator: (c, r) offset by k unit steps along dir, on the + or
// - side, with an on-board flag.
module win_scan_step
  import win_scan_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic signed [3:0] c,
  input  logic signed [3:0] r,
  input  dir_e              dir,
  input  logic              side_neg,
  input  logic        [2:0] k,
  output logic signed [3:0] tc,
  output logic signed [3:0] tr,
  output logic              in_bounds
);

  localparam logic signed [5:0] COLS_S = 6'(COLS);
  localparam logic signed [5:0] ROWS_S = 6'(ROWS);

  logic signed [5:0] k_s, dx_s, dy_s, off_x, off_y, c_w, r_w;

  // Work two bits wider than the 4-bit coordinates so c+k never wraps
  // back into the board.
  always_comb begin
    k_s   = $signed({3'b000, k});
    dx_s  = {{4{DIR_DX[dir][1]}}, DIR_DX[dir]};
    dy_s  = {{4{DIR_DY[dir][1]}}, DIR_DY[dir]};
    off_x = dx_s * k_s;
    off_y = dy_s * k_s;
    if (side_neg) begin
      off_x = -off_x;
      off_y = -off_y;
    end
    c_w       = {{2{c[3]}}, c} + off_x;
    r_w       = {{2{r[3]}}, r} + off_y;
    in_bounds = (c_w >= 6'sd0) && (c_w < COLS_S) && (r_w >= 6'sd0) && (r_w < ROWS_S);
    tc        = c_w[3:0];
    tr        = r_w[3:0];
  end

endmodule

// File: rtl/win_scan_ctrl.sv
// Serial four-in-a-row checker: reads one column per probe and walks the four
// line directions out from the placed disc. Draw detection: WIN_SCAN_DRAW_EN.
module win_scan_ctrl
  import win_scan_pkg::*;
#(
  parameter int COLS    = COLS_DEF,
  parameter int ROWS    = ROWS_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF
) (
  input logic            clk,
  input logic            reset,
  win_scan_ctrl_if.slave bus
);

  localparam logic [3:0] COLS_U = 4'(COLS);
  localparam logic [2:0] WL     = 3'(WIN_LEN);

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  logic              side_q, side_d;        // 0: + side, 1: - side
  logic        [2:0] k_q, k_d;
  logic        [2:0] run_q, run_d;
  logic signed [3:0] c_q, c_d;
  logic signed [3:0] r_q, r_d;
  logic              player_q, player_d;
  logic        [2:0] rd_addr_q, rd_addr_d;
  logic              win_q, win_d;
  logic              err_q, err_d;

  logic signed [3:0] tc, tr;
  logic              in_bounds;
  logic        [3:0] top_row;
  logic        [2:0] run_inc;
  logic              probe_hit;
  logic              end_side;
  logic              accept;
  logic              enter_done;

  win_scan_step #(.COLS(COLS), .ROWS(ROWS)) u_step (
    .c        (c_q),
    .r        (r_q),
    .dir      (dir_q),
    .side_neg (side_q),
    .k        (k_q),
    .tc       (tc),
    .tr       (tr),
    .in_bounds(in_bounds)
  );

  // The newest disc sits on top, so the last set bit scanning upward wins.
  always_comb begin
    top_row = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (bus.rd_onoff[i]) top_row = 4'(i);
    end
  end

  assign probe_hit = bus.rd_onoff[tr[2:0]] && (bus.rd_player[tr[2:0]] == player_q);
  assign run_inc   = (run_q >= WL) ? WL : run_q + 3'd1;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can infer a latch.
    state_d   = state_q;
    dir_d     = dir_q;
    side_d    = side_q;
    k_d       = k_q;
    run_d     = run_q;
    c_d       = c_q;
    r_d       = r_q;
    player_d  = player_q;
    rd_addr_d = rd_addr_q;
    win_d     = win_q;
    err_d     = err_q;
    end_side  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.go) begin
          win_d    = 1'b0;
          err_d    = 1'b0;
          c_d      = $signed({1'b0, bus.col});
          player_d = bus.player;
          if ({1'b0, bus.col} >= COLS_U) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            rd_addr_d = bus.col;
            state_d   = FIND_WAIT;
          end
        end
      end
      FIND_WAIT: state_d = FIND_EVAL;
      FIND_EVAL: begin
        if (bus.rd_onoff == '0) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          r_d     = $signed(top_row);
          run_d   = 3'd1;
          dir_d   = DIR_H;
          side_d  = 1'b0;
          k_d     = 3'd1;
          state_d = STEP;
        end
      end
      STEP: begin
        if (!in_bounds || k_q >= WL) begin
          end_side = 1'b1;
        end else begin
          rd_addr_d = tc[2:0];
          state_d   = PROBE_WAIT;
        end
      end
      PROBE_WAIT: state_d = PROBE_EVAL;
      PROBE_EVAL: begin
        if (probe_hit) begin
          run_d = run_inc;
          k_d   = k_q + 3'd1;
          if (run_inc >= WL) begin
            win_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = STEP;
          end
        end else begin
          end_side = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Side bookkeeping shared by out-of-bounds steps and mismatching probes.
    if (end_side) begin
      k_d = 3'd1;
      if (!side_q) begin
        side_d  = 1'b1;
        state_d = STEP;
      end else if (dir_q == DIR_D2) begin
        state_d = DONE;
      end else begin
        dir_d   = dir_e'(dir_q + 2'd1);
        side_d  = 1'b0;
        run_d   = 3'd1;
        state_d = STEP;
      end
    end
  end

  assign accept     = (state_q == IDLE) && bus.go;
  assign enter_done = (state_d == DONE) && (state_q != DONE);

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dir_q     <= DIR_H;
      side_q    <= 1'b0;
      k_q       <= 3'd0;
      run_q     <= 3'd0;
      c_q       <= 4'sd0;
      r_q       <= 4'sd0;
      player_q  <= 1'b0;
      rd_addr_q <= 3'd0;
      win_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      side_q    <= side_d;
      k_q       <= k_d;
      run_q     <= run_d;
      c_q       <= c_d;
      r_q       <= r_d;
      player_q  <= player_d;
      rd_addr_q <= rd_addr_d;
      win_q     <= win_d;
      err_q     <= err_d;
    end
  end

`ifdef WIN_SCAN_DRAW_EN
  localparam logic [5:0] TOTAL = 6'(COLS * ROWS);

  logic [5:0] moves_q, moves_d, moves_inc;
  logic       draw_q, draw_d;

  // Every completed, error-free scan is one move; the full-board move is a draw unless it wins.
  always_comb begin
    moves_inc = moves_q + 6'd1;
    moves_d   = moves_q;
    draw_d    = draw_q;
    if (accept) draw_d = 1'b0;
    if (bus.clear) begin
      moves_d = '0;
    end else if (enter_done && !err_d) begin
      moves_d = moves_inc;
      if (moves_inc == TOTAL && !win_d) draw_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      moves_q <= '0;
      draw_q  <= 1'b0;
    end else begin
      moves_q <= moves_d;
      draw_q  <= draw_d;
    end
  end

  assign bus.draw = draw_q;
`else
  logic unused_draw_inputs;
  assign unused_draw_inputs = bus.clear ^ accept ^ enter_done;
  assign bus.draw           = 1'b0;
`endif

  assign bus.rd_addr = rd_addr_q;
  assign bus.busy    = (state_q != IDLE) && (state_q != DONE);
  assign bus.done    = (state_q == DONE);
  assign bus.win     = win_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_win_scan_ctrl.sv
// Self-checking bench for win_scan_ctrl: directed cases plus random boards
// checked against a whole-board line-count model.
module tb_win_scan_ctrl;

  localparam int COLS    = 7;
  localparam int ROWS    = 6;
  localparam int WIN_LEN = 4;
`ifdef WIN_SCAN_DRAW_EN
  localparam bit DRAW_EN = 1'b1;
`else
  localparam bit DRAW_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  win_scan_ctrl_if #(.ROWS(ROWS)) bus ();

  win_scan_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Board register file: one-cycle registered column read.
  logic [5:0] b_on  [8];
  logic [5:0] b_own [8];
  always @(posedge clk) begin
    bus.rd_onoff  <= b_on[bus.rd_addr];
    bus.rd_player <= b_own[bus.rd_addr];
  end

  int total = 0;
  int bad   = 0;
  int moves = 0;
  int lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < 8; i++) begin
      b_on[i]  = '0;
      b_own[i] = '0;
    end
  endtask

  task automatic put(input int x, input int y, input bit p);
    b_on[x][y]  = 1'b1;
    b_own[x][y] = p;
  endtask

  // Win if the placed disc plus contiguous same-owner discs on both sides of
  // any line reaches WIN_LEN.
  function automatic void model(input int c, input bit p, output bit w, output bit e);
    int dxs [4] = '{1, 0, 1, 1};
    int dys [4] = '{0, 1, 1, -1};
    int r, cnt, x, y, s;
    w = 1'b0;
    e = 1'b0;
    if (c >= COLS) begin e = 1'b1; return; end
    if (b_on[c] == 6'd0) begin e = 1'b1; return; end
    r = 0;
    for (int i = 0; i < ROWS; i++) if (b_on[c][i]) r = i;
    for (int d = 0; d < 4; d++) begin
      cnt = 1;
      for (int si = 0; si < 2; si++) begin
        s = (si == 0) ? 1 : -1;
        for (int k = 1; k < WIN_LEN; k++) begin
          x = c + s * k * dxs[d];
          y = r + s * k * dys[d];
          if (x < 0 || x >= COLS || y < 0 || y >= ROWS) break;
          if (b_on[x][y] && b_own[x][y] == p) cnt++;
          else break;
        end
      end
      if (cnt >= WIN_LEN) w = 1'b1;
    end
  endfunction

  function automatic bit draw_expect(input bit ew, input bit ee);
    if (!ee) moves = (moves + 1) % 64;
    return DRAW_EN && !ee && !ew && (moves == COLS * ROWS);
  endfunction

  task automatic wait_done();
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_scan(input string tag, input int c, input bit p, input int exp_lat);
    bit ew, ee, ed;
    model(c, p, ew, ee);
    @(negedge clk);
    bus.go     = 1'b1;
    bus.col    = 3'(c);
    bus.player = p;
    @(negedge clk);
    bus.go = 1'b0;
    lat    = 1;
    wait_done();
    ed = draw_expect(ew, ee);
    check({tag, "_in_budget"}, 32'(lat <= 80), 1);
    if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_win"}, bus.win, ew);
    check({tag, "_err"}, bus.err, ee);
    check({tag, "_draw"}, bus.draw, ed);
    check({tag, "_busy_at_done"}, bus.busy, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 0);
    check({tag, "_win_held"}, bus.win, ew);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    moves     = 0;
  endtask

  initial begin
    bit ew, ee, ed;
    reset      = 1'b1;
    bus.go     = 1'b0;
    bus.col    = '0;
    bus.player = 1'b0;
    bus.clear  = 1'b0;
    clear_board();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_win", bus.win, 0);
    check("rst_err", bus.err, 0);
    check("rst_draw", bus.draw, 0);
    check("rst_rd_addr", bus.rd_addr, 0);

    // Horizontal win.
    for (int x = 0; x < 4; x++) put(x, 0, 1'b1);
    run_scan("horiz", 3, 1'b1, -1);
    check("horiz_win_const", bus.win, 1);

    // Vertical three only.
    clear_board();
    for (int y = 0; y < 3; y++) put(2, y, 1'b0);
    run_scan("three", 2, 1'b0, -1);
    check("three_win_const", bus.win, 0);

    // Rising diagonal with support discs owned by player 1.
    clear_board();
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < x; y++) put(x, y, 1'b1);
      put(x, x, 1'b0);
    end
    run_scan("diag", 3, 1'b0, -1);
    check("diag_win_const", bus.win, 1);

    // Empty and out-of-range columns.
    run_scan("empty", 5, 1'b0, 3);
    run_scan("badcol", 7, 1'b1, 1);

    // go while busy, then go on the DONE cycle: both ignored.
    clear_board();
    for (int x = 0; x < 4; x++) put(x, 0, 1'b1);
    model(3, 1'b1, ew, ee);
    @(negedge clk);
    bus.go = 1'b1; bus.col = 3'd3; bus.player = 1'b1;
    @(negedge clk);
    bus.go = 1'b0; lat = 1;
    repeat (2) @(negedge clk);
    lat += 2;
    check("midscan_busy", bus.busy, 1);
    bus.go = 1'b1; bus.col = 3'd5; bus.player = 1'b0;
    @(negedge clk);
    bus.go = 1'b0; lat++;
    wait_done();
    ed = draw_expect(ew, ee);
    check("busy_go_done_seen", bus.done, 1);
    check("busy_go_win", bus.win, ew);
    check("busy_go_err", bus.err, ee);
    bus.go = 1'b1; bus.col = 3'd7; bus.player = 1'b0;
    @(negedge clk);
    bus.go = 1'b0;
    check("done_go_dropped_busy", bus.busy, 0);
    check("done_go_dropped_done", bus.done, 0);
    check("done_go_win_held", bus.win, ew);
    check("done_go_err_held", bus.err, ee);

    // Reset in the middle of a scan.
    @(negedge clk);
    bus.go = 1'b1; bus.col = 3'd3; bus.player = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    repeat (4) @(negedge clk);
    check("prerst_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_win", bus.win, 0);
    check("midrst_err", bus.err, 0);
    check("midrst_draw", bus.draw, 0);
    check("midrst_rd_addr", bus.rd_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    moves = 0;
    repeat (3) @(negedge clk);
    check("postrst_idle", bus.busy, 0);
    run_scan("postrst", 3, 1'b1, -1);

    // Random boards.
    for (int n = 0; n < 40; n++) begin
      for (int x = 0; x < COLS; x++) begin
        int h;
        h        = $urandom_range(0, ROWS);
        b_on[x]  = 6'((1 << h) - 1);
        b_own[x] = 6'($urandom) & b_on[x];
      end
      run_scan("rand", $urandom_range(0, 7), 1'($urandom), -1);
    end

    // Draw on the full-board move, then cleared.
    clear_board();
    put(0, 0, 1'b1);
    pulse_clear();
    for (int i = 0; i < COLS * ROWS; i++) begin
      run_scan("drawseq", 0, 1'b1, -1);
      if (i == COLS * ROWS - 2) check("draw_not_early", bus.draw, 0);
    end
    check("draw_on_last", bus.draw, 32'(DRAW_EN));
    pulse_clear();
    run_scan("after_clear", 0, 1'b1, -1);
    check("after_clear_draw", bus.draw, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
